// File: rtl/i2c_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | i2c_pkg : shared types and defaults for the I2C bus conditioner    |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
package i2c_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_t;

  localparam int              c_sync_stages = 2;
  localparam int              c_filt_len    = 3;
  localparam int              c_to_w        = 16;
  localparam logic [15:0]     c_to_cycles   = 16'd50000;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_glitch_filter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | i2c_glitch_filter : synchroniser, run-length filter, edge strobes  |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module i2c_glitch_filter
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = c_sync_stages,
  parameter int FILT_LEN    = c_filt_len
) (
  input  logic clk,
  input  logic rstn,
  input  logic pin_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W     = $clog2(FILT_LEN) + 1;
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_sample;

  assign w_sample = r_sync[SYNC_STAGES-1];

  // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '1;
      r_cnt  <= '0;
      level  <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (w_sample == level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        level <= w_sample;
        r_cnt <= '0;
        rise  <= w_sample;
        fall  <= ~w_sample;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule : i2c_glitch_filter
`default_nettype wire

// File: rtl/i2c_bus_conditioner.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | i2c_bus_conditioner : filtered SCL/SDA, START/STOP, busy, timeout  |
// | Rev 1.0                                                            |
// +-------------------------------------------------------------------+
module i2c_bus_conditioner
  import i2c_pkg::*;
#(
  parameter int              SYNC_STAGES = c_sync_stages,
  parameter int              FILT_LEN    = c_filt_len,
  parameter int              TO_W        = c_to_w,
  parameter logic [TO_W-1:0] TO_CYCLES   = TO_W'(c_to_cycles)
) (
  input  logic clk,
  input  logic rstn,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_f,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic rstart_det,
  output logic stop_det,
  output logic bus_busy,
  output logic timeout
);

  localparam logic [TO_W-1:0] c_to_last = TO_CYCLES - TO_W'(1);

  bus_state_t      r_state;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_sda_rise, w_sda_fall;
  logic            w_scl_stable, w_start, w_stop, w_to_sat, w_to_hit;

  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .rstn(rstn), .pin_in(scl_in),
    .level(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .rstn(rstn), .pin_in(sda_in),
    .level(sda_f), .rise(w_sda_rise), .fall(w_sda_fall)
  );

  // SCL high now with no edge strobe means it was high last cycle too.
  assign w_scl_stable = scl_f & ~scl_rise & ~scl_fall;
  assign w_start      = w_sda_fall & w_scl_stable;
  assign w_stop       = w_sda_rise & w_scl_stable;
  assign w_to_sat     = (r_to_cnt == c_to_last);
  assign w_to_hit     = (r_state == BUSY) & ~scl_f & ~w_to_sat
                        & ((r_to_cnt + TO_W'(1)) == c_to_last);
  assign bus_busy     = (r_state == BUSY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_to_cnt   <= '0;
      start_det  <= 1'b0;
      rstart_det <= 1'b0;
      stop_det   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      start_det  <= w_start & (r_state == IDLE);
      rstart_det <= w_start & (r_state == BUSY);
      stop_det   <= w_stop;
      timeout    <= w_to_hit & ~w_stop;

      // A saturated count survives the drop to IDLE so the strobe cannot repeat.
      if (scl_f || ((r_state == IDLE) && !w_to_sat)) begin
        r_to_cnt <= '0;
      end else if ((r_state == BUSY) && !w_to_sat) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      case (r_state)
        IDLE:    if (w_start && !w_stop) r_state <= BUSY;
        BUSY:    if (w_stop || w_to_hit) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : i2c_bus_conditioner
`default_nettype wire
